// File: rtl/periph_slave_resp_port.sv
// periph_slave_resp_port: arbitrates PE requests onto one peripheral port and steers in-order responses back by one-hot ID.
// Rev 1.0. Optional macro PERIPH_SLV_RR_ARB_EN selects round-robin (defined) or fixed lowest-index priority (undefined).
`default_nettype none

module periph_slave_resp_port #(
   parameter int N_MASTER        = 16,
   parameter int ID_WIDTH        = N_MASTER,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BE_WIDTH        = DATA_WIDTH/8,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [N_MASTER-1:0]                   data_req_i,
   input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   data_add_i,
   input  logic [N_MASTER-1:0]                   data_wen_i,
   input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]   data_wdata_i,
   input  logic [N_MASTER-1:0][BE_WIDTH-1:0]     data_be_i,
   input  logic [N_MASTER-1:0][ID_WIDTH-1:0]     data_ID_i,
   output logic [N_MASTER-1:0]                   data_gnt_o,
   output logic                                  data_req_o,
   output logic [ADDR_WIDTH-1:0]                 data_add_o,
   output logic                                  data_wen_o,
   output logic [DATA_WIDTH-1:0]                 data_wdata_o,
   output logic [BE_WIDTH-1:0]                   data_be_o,
   input  logic                                  data_gnt_i,
   input  logic                                  data_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                 data_r_rdata_i,
   input  logic                                  data_r_opc_i,
   output logic [ID_WIDTH-1:0]                   data_r_valid_o,
   output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
   output logic                                  data_r_opc_o,
   output logic                                  err_orphan_o
);

   localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [N_MASTER-1:0] elig;
   logic [IDX_W-1:0]    winner;
   logic                any_elig;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;

   logic [ID_WIDTH-1:0] id_mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                err_orphan_q, err_orphan_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full is taken from registered occupancy only, so r_valid never reaches data_req_o.
   assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign elig       = fifo_full ? '0 : data_req_i;
   assign any_elig   = |elig;

`ifdef PERIPH_SLV_RR_ARB_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W:0]   cand;
   logic             hit;

   always_comb begin
      winner = '0;
      cand   = '0;
      hit    = 1'b0;
      for (int k = 0; k < N_MASTER; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_MASTER)) begin
            cand = cand - (IDX_W+1)'(N_MASTER);
         end
         if (!hit && elig[cand[IDX_W-1:0]]) begin
            hit    = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (winner == IDX_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   always_comb begin
      winner = '0;
      for (int k = N_MASTER - 1; k >= 0; k--) begin
         if (elig[k]) begin
            winner = IDX_W'(k);
         end
      end
   end
`endif

   assign push = any_elig & data_gnt_i;
   assign pop  = data_r_valid_i & ~fifo_empty;

   assign data_req_o   = any_elig;
   assign data_add_o   = data_add_i[winner];
   assign data_wen_o   = data_wen_i[winner];
   assign data_wdata_o = data_wdata_i[winner];
   assign data_be_o    = data_be_i[winner];

   always_comb begin
      data_gnt_o = '0;
      if (push) begin
         data_gnt_o[winner] = 1'b1;
      end
   end

   assign data_r_valid_o = pop ? id_mem_q[rd_ptr_q] : '0;
   assign data_r_rdata_o = data_r_rdata_i;
   assign data_r_opc_o   = data_r_opc_i;
   assign err_orphan_o   = err_orphan_q;

   always_comb begin
      wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d      = count_q;
      err_orphan_d = err_orphan_q | (data_r_valid_i & fifo_empty);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_orphan_q <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            id_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_orphan_q <= err_orphan_d;
         if (push) begin
            id_mem_q[wr_ptr_q] <= data_ID_i[winner];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_periph_slave_resp_port.sv
// tb_periph_slave_resp_port: directed and random checks of periph_slave_resp_port against a queue-based reference model.
// Rev 1.0. Honours PERIPH_SLV_RR_ARB_EN the same way as the design.
`default_nettype none

module tb_periph_slave_resp_port;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW/8;
   localparam int MO = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [N-1:0]         req;
   logic [N-1:0][AW-1:0] add;
   logic [N-1:0]         wen;
   logic [N-1:0][DW-1:0] wdata;
   logic [N-1:0][BW-1:0] be;
   logic [N-1:0][N-1:0]  id;
   logic [N-1:0]         gnt_o;
   logic                 req_o;
   logic [AW-1:0]        add_o;
   logic                 wen_o;
   logic [DW-1:0]        wdata_o;
   logic [BW-1:0]        be_o;
   logic                 gnt_i;
   logic                 r_valid_i;
   logic [DW-1:0]        rdata_i;
   logic                 opc_i;
   logic [N-1:0]         rvalid_o;
   logic [DW-1:0]        rdata_o;
   logic                 opc_o;
   logic                 orphan_o;

   always #5 clk = ~clk;

   periph_slave_resp_port #(
      .N_MASTER(N), .ID_WIDTH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .data_req_i(req), .data_add_i(add), .data_wen_i(wen), .data_wdata_i(wdata),
      .data_be_i(be), .data_ID_i(id), .data_gnt_o(gnt_o),
      .data_req_o(req_o), .data_add_o(add_o), .data_wen_o(wen_o),
      .data_wdata_o(wdata_o), .data_be_o(be_o), .data_gnt_i(gnt_i),
      .data_r_valid_i(r_valid_i), .data_r_rdata_i(rdata_i), .data_r_opc_i(opc_i),
      .data_r_valid_o(rvalid_o), .data_r_rdata_o(rdata_o), .data_r_opc_o(opc_o),
      .err_orphan_o(orphan_o)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: in-flight IDs in issue order, arbitration pointer, sticky orphan flag.
   logic [N-1:0] mq[$];
   int           m_ptr = 0;
   logic         m_orphan = 1'b0;
   logic         e_xfer;
   int           e_win;
   logic [N-1:0] obs_gnt, obs_rv;
   logic         obs_req, obs_orphan;
   logic [DW-1:0] obs_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] el, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (el[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   task automatic step();
      logic [N-1:0] el, eg, erv;
      @(negedge clk);
      el     = (mq.size() >= MO) ? '0 : req;
      e_win  = pick(el, m_ptr);
      e_xfer = (el != '0) && gnt_i;
      eg     = e_xfer ? (N'(1) << e_win) : '0;
      erv    = (r_valid_i && mq.size() > 0) ? mq[0] : '0;
      obs_gnt = gnt_o; obs_rv = rvalid_o; obs_req = req_o;
      obs_orphan = orphan_o; obs_rdata = rdata_o;
      check("req_o", req_o, el != '0);
      check("gnt_o", gnt_o, eg);
      check("r_valid_o", rvalid_o, erv);
      check("r_rdata_o", rdata_o, rdata_i);
      check("r_opc_o", opc_o, opc_i);
      check("err_orphan_o", orphan_o, m_orphan);
      if (el != '0) begin
         check("add_o", add_o, add[e_win]);
         check("wen_o", wen_o, wen[e_win]);
         check("wdata_o", wdata_o, wdata[e_win]);
         check("be_o", be_o, be[e_win]);
      end
      @(posedge clk);
      if (r_valid_i) begin
         if (mq.size() > 0) void'(mq.pop_front());
         else m_orphan = 1'b1;
      end
      if (e_xfer) begin
         mq.push_back(id[e_win]);
`ifdef PERIPH_SLV_RR_ARB_EN
         m_ptr = (e_win + 1) % N;
`endif
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0; gnt_i = 1'b0; r_valid_i = 1'b1;
      #2;
      check("rst_orphan", orphan_o, 1'b0);
      check("rst_r_valid_o", rvalid_o, '0);
      check("rst_gnt_o", gnt_o, '0);
      check("rst_req_o", req_o, 1'b0);
      mq.delete(); m_ptr = 0; m_orphan = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      r_valid_i = 1'b0;
   endtask

   initial begin
      req = '0; add = '0; wen = '1; wdata = '0; be = '0;
      gnt_i = 1'b0; r_valid_i = 1'b0; rdata_i = '0; opc_i = 1'b0;
      for (int p = 0; p < N; p++) id[p] = N'(1) << p;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      step();

      // Single access: PE2 read, response two cycles later
      req = 4'b0100; add[2] = 32'h1A10_0004; wen[2] = 1'b1; gnt_i = 1'b1;
      step();
      check("single_gnt", obs_gnt, 4'b0100);
      req = '0; gnt_i = 1'b0;
      step();
      r_valid_i = 1'b1; rdata_i = 32'hDEAD_BEEF; opc_i = 1'b0;
      step();
      check("single_rvalid", obs_rv, 4'b0100);
      check("single_rdata", obs_rdata, 32'hDEAD_BEEF);
      r_valid_i = 1'b0;

      // Contention: all PEs request, responses one cycle after each grant
      do_reset();
      req = 4'hF; gnt_i = 1'b1;
      for (int k = 0; k < 9; k++) begin
         r_valid_i = (k > 0);
         step();
`ifdef PERIPH_SLV_RR_ARB_EN
         check("rr_gnt", obs_gnt, 4'(1) << (k % 4));
         if (k > 0) check("rr_rvalid", obs_rv, 4'(1) << ((k - 1) % 4));
`else
         check("fp_gnt", obs_gnt, 4'b0001);
`endif
      end
      req = '0; r_valid_i = 1'b1;
      step();
      r_valid_i = 1'b0;

      // FIFO full
      gnt_i = 1'b1;
      req = 4'b0010; step();
      req = 4'b1000; step();
      req = 4'b0001; step();
      check("full_req_o", obs_req, 1'b0);
      check("full_gnt", obs_gnt, 4'b0000);
      r_valid_i = 1'b1; step();
      check("full_rvalid", obs_rv, 4'b0010);
      check("full_gnt_pop", obs_gnt, 4'b0000);
      r_valid_i = 1'b0; step();
      check("full_regrant", obs_gnt, 4'b0001);

      // Simultaneous push/pop at occupancy 1
      req = '0; r_valid_i = 1'b1; step();
      check("drain_rvalid", obs_rv, 4'b1000);
      req = 4'b0100; step();
      check("pp_rvalid", obs_rv, 4'b0001);
      check("pp_gnt", obs_gnt, 4'b0100);
      req = '0; step();
      check("pp_next", obs_rv, 4'b0100);

      // Orphan
      step();
      check("orphan_rvalid", obs_rv, 4'b0000);
      r_valid_i = 1'b0; step();
      check("orphan_flag", obs_orphan, 1'b1);

      // Reset with two IDs outstanding
      req = 4'b0011; gnt_i = 1'b1; step(); step();
      do_reset();
      r_valid_i = 1'b1; step();
      check("post_rst_rvalid", obs_rv, 4'b0000);
      r_valid_i = 1'b0; step();
      check("post_rst_orphan", obs_orphan, 1'b1);

      // Two contenders held continuously
      req = 4'b1010; gnt_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         r_valid_i = (k > 0);
         step();
`ifndef PERIPH_SLV_RR_ARB_EN
         check("fp_pe1", obs_gnt, 4'b0010);
`endif
      end

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         req = 4'($urandom);
         for (int p = 0; p < N; p++) begin
            add[p] = $urandom; wdata[p] = $urandom;
            wen[p] = 1'($urandom); be[p] = 4'($urandom);
         end
         gnt_i = ($urandom_range(0, 3) != 0);
         r_valid_i = 1'($urandom);
         rdata_i = $urandom; opc_i = 1'($urandom);
         if (k == 200) do_reset();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/periph_slave_resp_port.md
Name: periph_slave_resp_port

Overview:
- Slave-end counterpart of the PE-side request decoder / response tree in the peripheral interconnect.
- Sits in front of one peripheral target (timer, event unit, DMA config port, …).
- Arbitrates N_MASTER PE request channels onto the single peripheral port and records the winner's one-hot ID per accepted request.
- Steers the peripheral's in-order responses back to the originating PE; the peripheral may have variable response latency.

Parameters:
- N_MASTER, 16, number of PE request channels.
- ID_WIDTH, N_MASTER, width of the one-hot PE ID carried with each request. Must equal N_MASTER.
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, write/read data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_OUTSTANDING, 2, depth of the in-flight ID FIFO. Must be ≥1; need not be a power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  N_MASTER  per-PE request
- data_add_i  in  N_MASTER×ADDR_WIDTH  per-PE address
- data_wen_i  in  N_MASTER  per-PE write-enable, active-low (0 = write)
- data_wdata_i  in  N_MASTER×DATA_WIDTH  per-PE write data
- data_be_i  in  N_MASTER×BE_WIDTH  per-PE byte enables
- data_ID_i  in  N_MASTER×ID_WIDTH  per-PE one-hot ID
- data_gnt_o  out  N_MASTER  per-PE grant, at most one bit high
- data_req_o  out  1  request to peripheral
- data_add_o  out  ADDR_WIDTH  muxed address
- data_wen_o  out  1  muxed write-enable
- data_wdata_o  out  DATA_WIDTH  muxed write data
- data_be_o  out  BE_WIDTH  muxed byte enables
- data_gnt_i  in  1  peripheral grant
- data_r_valid_i  in  1  peripheral response valid
- data_r_rdata_i  in  DATA_WIDTH  peripheral read data
- data_r_opc_i  in  1  peripheral response error/opcode
- data_r_valid_o  out  ID_WIDTH  one-hot response valid toward PEs
- data_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all PEs
- data_r_opc_o  out  1  response opcode, broadcast to all PEs
- err_orphan_o  out  1  sticky flag: response received with no outstanding request

Behaviour:
- Clock and reset: single clk; rst_n is asynchronous assert, active-low.
- Reset values:
  - FIFO empty, occupancy counter 0, RR pointer 0, err_orphan_o 0.
  - data_req_o 0, data_gnt_o 0, data_r_valid_o 0.
  - Datapath outputs follow the mux/broadcast logic and are don't-care while the associated valid is 0.
- Arbitration (combinational):
  - Eligible set is data_req_i, masked to 0 when the FIFO is full.
  - Winner is the first eligible index at or above the RR pointer, wrapping modulo N_MASTER.
  - data_req_o = any eligible. data_add/wen/wdata/be_o = the winner's fields.
- Handshake:
  - Transfer occurs when data_req_o and data_gnt_i are both 1.
  - In that cycle data_gnt_o[winner] = 1, all other grant bits 0.
  - Zero-latency request path: grant is same-cycle, with no register between PE and peripheral.
- RR update: on transfer, the pointer becomes (winner+1) mod N_MASTER; otherwise it holds.
- ID FIFO:
  - On transfer, push data_ID_i[winner].
  - On data_r_valid_i with FIFO non-empty, pop.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Full blocks new requests even if a pop occurs the same cycle. This avoids a combinational path from data_r_valid_i to data_req_o.
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Response path (combinational, zero added latency):
  - data_r_valid_o = FIFO head ID when data_r_valid_i is 1 and the FIFO is non-empty; otherwise all zeros.
  - data_r_rdata_o = data_r_rdata_i; data_r_opc_o = data_r_opc_i.
  - Writes also receive a response, since the peripheral responds to every request.
- Orphan response: data_r_valid_i with an empty FIFO is dropped; no data_r_valid_o bit asserts. err_orphan_o is set to 1 and stays set until reset.
- Same-cycle response to the current request: not supported; the peripheral's response latency must be ≥1 cycle. A push is never visible at the FIFO head until the next cycle.
- Reset mid-operation: all in-flight IDs are discarded immediately. Responses arriving after reset release are orphans.
- Requests not granted: PEs hold req and fields stable until granted. This block neither latches nor drops requests.

Optional Feature:
- Macro: PERIPH_SLV_RR_ARB_EN.
- Defined: round-robin arbitration with pointer, as specified above.
- Undefined: fixed priority, lowest index wins. No pointer register is built; everything else is identical.

Test Plan:
- Single access (N_MASTER=4, MAX_OUTSTANDING=2):
  - Stimulus: PE2 read, addr 0x1A10_0004; data_gnt_i=1; peripheral returns r_valid 2 cycles later with rdata 0xDEADBEEF, opc 0.
  - Response: data_gnt_o=0100 in the request cycle; data_r_valid_o=0100 with rdata 0xDEADBEEF.
- Contention (RR enabled):
  - Stimulus: PE0–PE3 request continuously; data_gnt_i=1; responses after 1 cycle.
  - Response: grants in order PE0, PE1, PE2, PE3, PE0, …; response one-hots follow the same order one cycle later.
- FIFO full:
  - Stimulus: data_gnt_i=1, two transfers (PE1, PE3), no r_valid.
  - Response: third request sees data_req_o=0 and data_gnt_o=0000. After one r_valid: data_r_valid_o=0010, then the request is re-granted the following cycle.
- Simultaneous push/pop at occupancy 1:
  - Stimulus: r_valid_i and a new transfer in the same cycle.
  - Response: occupancy stays 1; the popped ID goes to the earlier PE; the next response goes to the new PE.
- Orphan response and reset:
  - Stimulus: r_valid_i with an empty FIFO.
  - Response: data_r_valid_o=0000; err_orphan_o=1 from the next cycle.
  - Stimulus: assert rst_n=0 with 2 IDs outstanding.
  - Response: err_orphan_o=0 and the FIFO is empty immediately. A subsequent r_valid_i is treated as an orphan.
- Fixed priority (PERIPH_SLV_RR_ARB_EN undefined):
  - Stimulus: PE1 and PE3 request continuously.
  - Response: PE1 is granted every cycle; PE3 is never granted while PE1 requests.
